// File: rtl/lsu_bus_pkg.sv
// Shared types and lane helpers for the lsu_bus load/store initiator.
// LSU_BUS_MISALIGNED_EN enables two-transfer handling of lane-crossing accesses.
package lsu_bus_pkg;

    typedef enum logic [1:0] {
        SIZ_B = 2'd0,
        SIZ_H = 2'd1,
        SIZ_W = 2'd2,
        SIZ_X = 2'd3
    } siz_t;

`ifdef LSU_BUS_MISALIGNED_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REQ2 = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    // Read path sees {second word, first word} when an access is split.
    localparam int RW = 64;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam int RW = 32;
`endif

    // Lane mask over two consecutive words; bits [7:4] belong to the next word.
    function automatic logic [7:0] sel_f(siz_t siz, logic [1:0] off);
        case (siz)
            SIZ_B:   return 8'b0000_0001 << off;
            SIZ_H:   return 8'b0000_0011 << off;
            SIZ_W:   return 8'b0000_1111 << off;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic legal_f(siz_t siz, logic [1:0] off);
`ifdef LSU_BUS_MISALIGNED_EN
        return (siz != SIZ_X) && (off == off);
`else
        case (siz)
            SIZ_B:   return 1'b1;
            SIZ_H:   return !off[0];
            SIZ_W:   return off == 2'b00;
            default: return 1'b0;
        endcase
`endif
    endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// req/wen/sel/adr/wdt/rdt/ack memory bus; read data arrives the cycle after a read transfer.
interface lsu_bus_if #(
    parameter int AW = 32
);
    logic          req;
    logic          wen;
    logic [3:0]    sel;
    logic [AW-1:0] adr;
    logic [31:0]   wdt;
    logic [31:0]   rdt;
    logic          ack;

    modport master (output req, wen, sel, adr, wdt, input rdt, ack);
    modport slave  (input req, wen, sel, adr, wdt, output rdt, ack);
endinterface

// File: rtl/lsu_bus_fmt.sv
// Read-data formatter: shifts the addressed lanes down and sign/zero-extends to 32 bits.
module lsu_bus_fmt
    import lsu_bus_pkg::*;
#(
    parameter int RW = 32
) (
    input  logic [RW-1:0] rdt_i,
    input  logic [1:0]    off_i,
    input  siz_t          siz_i,
    input  logic          uns_i,
    output logic [31:0]   dat_o
);
    logic [31:0] w;

    assign w = 32'(rdt_i >> {off_i, 3'b000});

    // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        dat_o = w;
        case (siz_i)
            SIZ_B:   dat_o = {{24{!uns_i & w[7]}}, w[7:0]};
            SIZ_H:   dat_o = {{16{!uns_i & w[15]}}, w[15:0]};
            default: dat_o = w;
        endcase
    end
endmodule

// File: rtl/lsu_bus.sv
// lsu_bus: turns one core byte/half/word access into aligned bus transfers, one access in flight.
// Define LSU_BUS_MISALIGNED_EN to split lane-crossing half/word accesses into two transfers.
module lsu_bus
    import lsu_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ls_vld,
    output logic          ls_rdy,
    input  logic          ls_wen,
    input  logic [1:0]    ls_siz,
    input  logic          ls_uns,
    input  logic [AW-1:0] ls_adr,
    input  logic [31:0]   ls_wdt,
    output logic          rsp_vld,
    output logic          rsp_err,
    output logic [31:0]   rsp_rdt,
    lsu_bus_if.master     bus
);
    if (DW != 32) begin : g_dw_chk
        $error("lsu_bus: only DW=32 is supported");
    end

    state_t        state_q, state_d;
    logic          req_q, wen_q, uns_q, err_q;
    siz_t          siz_q;
    logic [1:0]    off_q;
    logic [3:0]    sel_q;
    logic [AW-1:0] adr_q;
    logic [31:0]   wdt_q;

    logic [1:0]    off;
    logic          accept, legal;
    logic [3:0]    sel_n;
    logic [31:0]   wdt_n;
    logic [RW-1:0] fmt_in;
    logic [31:0]   fmt_dat;

    assign off    = ls_adr[1:0];
    assign ls_rdy = (state_q == ST_IDLE);
    assign accept = ls_vld & ls_rdy;
    assign legal  = legal_f(siz_t'(ls_siz), off);

`ifdef LSU_BUS_MISALIGNED_EN
    logic          split_q, cap_q;
    logic [3:0]    sel2_q;
    logic [31:0]   wdt2_q, rdt1_q;
    logic [7:0]    sel8;
    logic [63:0]   wdt64;

    assign sel8   = sel_f(siz_t'(ls_siz), off);
    assign wdt64  = {32'b0, ls_wdt} << {off, 3'b000};
    assign sel_n  = sel8[3:0];
    assign wdt_n  = wdt64[31:0];
    assign fmt_in = split_q ? {bus.rdt, rdt1_q} : {32'b0, bus.rdt};
`else
    assign sel_n  = 4'(sel_f(siz_t'(ls_siz), off));
    assign wdt_n  = ls_wdt << {off, 3'b000};
    assign fmt_in = bus.rdt;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = legal ? ST_REQ : ST_RSP;
`ifdef LSU_BUS_MISALIGNED_EN
            ST_REQ:  if (bus.ack) state_d = split_q ? ST_REQ2 : ST_RSP;
            ST_REQ2: if (bus.ack) state_d = ST_RSP;
`else
            ST_REQ:  if (bus.ack) state_d = ST_RSP;
`endif
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            siz_q   <= SIZ_B;
            off_q   <= 2'b00;
            sel_q   <= '0;
            adr_q   <= '0;
            wdt_q   <= '0;
`ifdef LSU_BUS_MISALIGNED_EN
            split_q <= 1'b0;
            cap_q   <= 1'b0;
            sel2_q  <= '0;
            wdt2_q  <= '0;
            rdt1_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef LSU_BUS_MISALIGNED_EN
            // First read word is only valid in the cycle right after transfer one.
            if (cap_q) begin
                rdt1_q <= bus.rdt;
                cap_q  <= 1'b0;
            end
`endif
            if (accept) begin
                req_q <= legal;
                wen_q <= ls_wen;
                uns_q <= ls_uns;
                err_q <= !legal;
                siz_q <= siz_t'(ls_siz);
                off_q <= off;
                sel_q <= sel_n;
                adr_q <= {ls_adr[AW-1:2], 2'b00};
                wdt_q <= wdt_n;
`ifdef LSU_BUS_MISALIGNED_EN
                split_q <= legal && (sel8[7:4] != 4'b0000);
                sel2_q  <= sel8[7:4];
                wdt2_q  <= wdt64[63:32];
`endif
            end else if (state_q == ST_REQ && bus.ack) begin
`ifdef LSU_BUS_MISALIGNED_EN
                if (split_q) begin
                    sel_q <= sel2_q;
                    adr_q <= adr_q + AW'(4);
                    wdt_q <= wdt2_q;
                    cap_q <= 1'b1;
                end else begin
                    req_q <= 1'b0;
                end
`else
                req_q <= 1'b0;
`endif
            end
`ifdef LSU_BUS_MISALIGNED_EN
            else if (state_q == ST_REQ2 && bus.ack) begin
                req_q <= 1'b0;
            end
`endif
        end
    end

    lsu_bus_fmt #(.RW(RW)) u_fmt (
        .rdt_i (fmt_in),
        .off_i (off_q),
        .siz_i (siz_q),
        .uns_i (uns_q),
        .dat_o (fmt_dat)
    );

    assign bus.req = req_q;
    assign bus.wen = wen_q;
    assign bus.sel = sel_q;
    assign bus.adr = adr_q;
    assign bus.wdt = wdt_q;

    assign rsp_vld = (state_q == ST_RSP);
    assign rsp_err = rsp_vld & err_q;
    assign rsp_rdt = (rsp_vld && !err_q && !wen_q) ? fmt_dat : 32'b0;
endmodule
